// File: rtl/pipe_execute_stage.sv
// Execute stage: E pipeline register, ALU with operand muxing, condition-code
// register and the cmovXX/jXX condition evaluator.
module pipe_execute_stage #(
  parameter int WIDTH   = 64,
  parameter bit EXT_ALU = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             E_stall,
  input  logic             E_bubble,
  input  logic [2:0]       d_stat,
  input  logic [3:0]       d_icode,
  input  logic [3:0]       d_ifun,
  input  logic [WIDTH-1:0] d_valC,
  input  logic [WIDTH-1:0] d_valA,
  input  logic [WIDTH-1:0] d_valB,
  input  logic [3:0]       d_dstE,
  input  logic [3:0]       d_dstM,
  input  logic [2:0]       m_stat,
  input  logic [2:0]       W_stat,
  output logic [2:0]       e_stat,
  output logic [3:0]       e_icode,
  output logic             e_Cnd,
  output logic [WIDTH-1:0] e_valE,
  output logic [WIDTH-1:0] e_valA,
  output logic [3:0]       e_dstE,
  output logic [3:0]       e_dstM,
  output logic [2:0]       cc
);

  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;
  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [WIDTH-1:0] EIGHT = WIDTH'(8);

  logic [2:0]       ex_stat;
  logic [3:0]       ex_icode;
  logic [3:0]       ex_ifun;
  logic [WIDTH-1:0] ex_valC;
  logic [WIDTH-1:0] ex_valA;
  logic [WIDTH-1:0] ex_valB;
  logic [3:0]       ex_dstE;
  logic [3:0]       ex_dstM;
  logic [2:0]       cc_q;

  always_ff @(posedge clk) begin
    if (reset || E_bubble) begin
      ex_stat  <= STAT_AOK;
      ex_icode <= I_NOP;
      ex_ifun  <= '0;
      ex_valC  <= '0;
      ex_valA  <= '0;
      ex_valB  <= '0;
      ex_dstE  <= REG_NONE;
      ex_dstM  <= REG_NONE;
    end else if (!E_stall) begin
      ex_stat  <= d_stat;
      ex_icode <= d_icode;
      ex_ifun  <= d_ifun;
      ex_valC  <= d_valC;
      ex_valA  <= d_valA;
      ex_valB  <= d_valB;
      ex_dstE  <= d_dstE;
      ex_dstM  <= d_dstM;
    end
  end

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_fun;
  logic [WIDTH-1:0] alu_res;
  logic             is_add;
  logic             is_sub;

  always_comb begin
    alu_a = '0;
    alu_b = '0;
    case (ex_icode)
      I_RRMOVQ, I_OPQ:            alu_a = ex_valA;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = ex_valC;
      I_CALL, I_PUSHQ:            alu_a = -EIGHT;
      I_RET, I_POPQ:              alu_a = EIGHT;
      default:                    alu_a = '0;
    endcase
    case (ex_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = ex_valB;
      default: alu_b = '0;
    endcase
  end

  assign alu_fun = (ex_icode == I_OPQ) ? ex_ifun : 4'd0;

  always_comb begin
    alu_res = alu_b + alu_a;
    is_add  = 1'b0;
    is_sub  = 1'b0;
    case (alu_fun)
      4'd1: begin
        alu_res = alu_b - alu_a;
        is_sub  = 1'b1;
      end
      4'd2: alu_res = alu_b & alu_a;
      4'd3: alu_res = alu_b ^ alu_a;
      // Without the extension, ifun 4 falls back to add like any other undefined op.
      4'd4: begin
        if (EXT_ALU) begin
          alu_res = alu_b << alu_a[5:0];
        end else begin
          is_add = 1'b1;
        end
      end
      default: is_add = 1'b1;
    endcase
  end

  logic new_zf;
  logic new_sf;
  logic new_of;
  logic set_cc;

  assign new_zf = (alu_res == '0);
  assign new_sf = alu_res[WIDTH-1];
  assign new_of = (is_add && (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (alu_res[WIDTH-1] != alu_a[WIDTH-1]))
               || (is_sub && (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (alu_res[WIDTH-1] != alu_b[WIDTH-1]));

  // Flags are only committed when no older or current instruction has faulted.
  assign set_cc = (ex_icode == I_OPQ) && (ex_stat == STAT_AOK)
               && (m_stat == STAT_AOK) && (W_stat == STAT_AOK);

  always_ff @(posedge clk) begin
    if (reset) begin
      cc_q <= 3'b100;
    end else if (set_cc) begin
      cc_q <= {new_zf, new_sf, new_of};
    end
  end

  logic zf;
  logic sf;
  logic of;
  logic cond;

  assign {zf, sf, of} = cc_q;

  always_comb begin
    cond = 1'b0;
    case (ex_ifun)
      4'd0:    cond = 1'b1;
      4'd1:    cond = (sf ^ of) | zf;
      4'd2:    cond = sf ^ of;
      4'd3:    cond = zf;
      4'd4:    cond = ~zf;
      4'd5:    cond = ~(sf ^ of);
      4'd6:    cond = ~(sf ^ of) & ~zf;
      default: cond = 1'b0;
    endcase
  end

  assign e_Cnd   = ((ex_icode == I_RRMOVQ) || (ex_icode == I_JXX)) && cond;
  assign e_dstE  = ((ex_icode == I_RRMOVQ) && !e_Cnd) ? REG_NONE : ex_dstE;
  assign e_stat  = ex_stat;
  assign e_icode = ex_icode;
  assign e_valE  = alu_res;
  assign e_valA  = ex_valA;
  assign e_dstM  = ex_dstM;
  assign cc      = cc_q;

endmodule

// File: tb/tb_pipe_execute_stage.sv
// Bench for pipe_execute_stage: directed cases plus randomized traffic on a
// 64-bit base instance and a 16-bit instance with the shift extension.
module tb_pipe_execute_stage;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } ereg_t;

  logic        clk = 1'b0;
  logic        reset, E_stall, E_bubble;
  logic [2:0]  d_stat, m_stat, W_stat;
  logic [3:0]  d_icode, d_ifun, d_dstE, d_dstM;
  logic [63:0] d_valC, d_valA, d_valB;

  logic [2:0]  e_stat, cc;
  logic [3:0]  e_icode, e_dstE, e_dstM;
  logic        e_Cnd;
  logic [63:0] e_valE, e_valA;

  logic [2:0]  e16_stat, cc16;
  logic [3:0]  e16_icode, e16_dstE, e16_dstM;
  logic        e16_Cnd;
  logic [15:0] e16_valE, e16_valA;

  int n_cmp = 0;
  int n_bad = 0;

  ereg_t       m64, m16;
  logic [2:0]  mcc64, mcc16;

  always #5 clk = ~clk;

  pipe_execute_stage #(.WIDTH(64), .EXT_ALU(1'b0)) dut (
    .clk(clk), .reset(reset), .E_stall(E_stall), .E_bubble(E_bubble),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_valC(d_valC), .d_valA(d_valA), .d_valB(d_valB),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .m_stat(m_stat), .W_stat(W_stat),
    .e_stat(e_stat), .e_icode(e_icode), .e_Cnd(e_Cnd), .e_valE(e_valE),
    .e_valA(e_valA), .e_dstE(e_dstE), .e_dstM(e_dstM), .cc(cc));

  pipe_execute_stage #(.WIDTH(16), .EXT_ALU(1'b1)) dut16 (
    .clk(clk), .reset(reset), .E_stall(E_stall), .E_bubble(E_bubble),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun),
    .d_valC(d_valC[15:0]), .d_valA(d_valA[15:0]), .d_valB(d_valB[15:0]),
    .d_dstE(d_dstE), .d_dstM(d_dstM), .m_stat(m_stat), .W_stat(W_stat),
    .e_stat(e16_stat), .e_icode(e16_icode), .e_Cnd(e16_Cnd), .e_valE(e16_valE),
    .e_valA(e16_valA), .e_dstE(e16_dstE), .e_dstM(e16_dstM), .cc(cc16));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] wmask(input int w);
    return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
  endfunction

  function automatic logic signed [127:0] sext(input logic [63:0] v, input int w);
    logic [127:0] r;
    r = {64'b0, v & wmask(w)};
    if (r[w-1]) r = r | ~{64'b0, wmask(w)};
    return $signed(r);
  endfunction

  function automatic logic [63:0] opnd_a(input ereg_t e, input int w);
    case (e.icode)
      4'h2, 4'h6:       return e.valA & wmask(w);
      4'h3, 4'h4, 4'h5: return e.valC & wmask(w);
      4'h8, 4'hA:       return (64'd0 - 64'd8) & wmask(w);
      4'h9, 4'hB:       return 64'd8;
      default:          return 64'd0;
    endcase
  endfunction

  function automatic logic [63:0] opnd_b(input ereg_t e, input int w);
    case (e.icode)
      4'h4, 4'h5, 4'h6, 4'h8, 4'h9, 4'hA, 4'hB: return e.valB & wmask(w);
      default: return 64'd0;
    endcase
  endfunction

  function automatic logic [3:0] op_of(input ereg_t e);
    return (e.icode == 4'h6) ? e.ifun : 4'd0;
  endfunction

  function automatic logic [63:0] ref_valE(input ereg_t e, input int w, input bit ext);
    logic [63:0] a, b, r;
    logic [3:0]  f;
    a = opnd_a(e, w);
    b = opnd_b(e, w);
    f = op_of(e);
    if (f == 4'd1)              r = b - a;
    else if (f == 4'd2)         r = b & a;
    else if (f == 4'd3)         r = b ^ a;
    else if (ext && f == 4'd4)  r = b << a[5:0];
    else                        r = b + a;
    return r & wmask(w);
  endfunction

  function automatic logic [2:0] ref_flags(input ereg_t e, input int w, input bit ext);
    logic [63:0] r;
    logic [3:0]  f;
    logic signed [127:0] t, lim;
    logic of;
    r   = ref_valE(e, w, ext);
    f   = op_of(e);
    lim = 128'sd1 <<< (w - 1);
    of  = 1'b0;
    if (f == 4'd1) begin
      t  = sext(opnd_b(e, w), w) - sext(opnd_a(e, w), w);
      of = (t >= lim) || (t < -lim);
    end else if (f != 4'd2 && f != 4'd3 && !(ext && f == 4'd4)) begin
      t  = sext(opnd_b(e, w), w) + sext(opnd_a(e, w), w);
      of = (t >= lim) || (t < -lim);
    end
    return {r == 64'd0, r[w-1], of};
  endfunction

  function automatic logic ref_cnd(input ereg_t e, input logic [2:0] c);
    logic z, s, o, lt;
    {z, s, o} = c;
    lt = s ^ o;
    if (e.icode != 4'h2 && e.icode != 4'h7) return 1'b0;
    case (e.ifun)
      4'd0: return 1'b1;
      4'd1: return lt | z;
      4'd2: return lt;
      4'd3: return z;
      4'd4: return !z;
      4'd5: return !lt;
      4'd6: return !lt && !z;
      default: return 1'b0;
    endcase
  endfunction

  function automatic ereg_t bubble_val();
    ereg_t b;
    b = '0;
    b.stat = 3'd1; b.icode = 4'h1; b.dstE = 4'hF; b.dstM = 4'hF;
    return b;
  endfunction

  task automatic model_edge();
    ereg_t in64, in16;
    in64 = '{d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB, d_dstE, d_dstM};
    in16 = in64;
    in16.valC = d_valC & 64'hFFFF; in16.valA = d_valA & 64'hFFFF; in16.valB = d_valB & 64'hFFFF;
    if (reset) begin
      m64 = bubble_val(); m16 = bubble_val();
      mcc64 = 3'b100; mcc16 = 3'b100;
    end else begin
      if (m_stat == 3'd1 && W_stat == 3'd1) begin
        if (m64.icode == 4'h6 && m64.stat == 3'd1) mcc64 = ref_flags(m64, 64, 1'b0);
        if (m16.icode == 4'h6 && m16.stat == 3'd1) mcc16 = ref_flags(m16, 16, 1'b1);
      end
      if (E_bubble) begin
        m64 = bubble_val(); m16 = bubble_val();
      end else if (!E_stall) begin
        m64 = in64; m16 = in16;
      end
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    logic c64, c16;
    c64 = ref_cnd(m64, mcc64);
    c16 = ref_cnd(m16, mcc16);
    chk("stat64",  64'(e_stat),  64'(m64.stat));
    chk("icode64", 64'(e_icode), 64'(m64.icode));
    chk("cnd64",   64'(e_Cnd),   64'(c64));
    chk("valE64",  e_valE,       ref_valE(m64, 64, 1'b0));
    chk("valA64",  e_valA,       m64.valA);
    chk("dstE64",  64'(e_dstE),  64'((m64.icode == 4'h2 && !c64) ? 4'hF : m64.dstE));
    chk("dstM64",  64'(e_dstM),  64'(m64.dstM));
    chk("cc64",    64'(cc),      64'(mcc64));
    chk("stat16",  64'(e16_stat),  64'(m16.stat));
    chk("icode16", 64'(e16_icode), 64'(m16.icode));
    chk("cnd16",   64'(e16_Cnd),   64'(c16));
    chk("valE16",  64'(e16_valE),  ref_valE(m16, 16, 1'b1));
    chk("valA16",  64'(e16_valA),  m16.valA);
    chk("dstE16",  64'(e16_dstE),  64'((m16.icode == 4'h2 && !c16) ? 4'hF : m16.dstE));
    chk("dstM16",  64'(e16_dstM),  64'(m16.dstM));
    chk("cc16",    64'(cc16),      64'(mcc16));
  endtask

  task automatic load(input logic [3:0] icode, input logic [3:0] ifun,
                      input logic [63:0] va, input logic [63:0] vb, input logic [3:0] dste);
    d_stat = 3'd1; d_icode = icode; d_ifun = ifun; d_valC = 64'd0;
    d_valA = va; d_valB = vb; d_dstE = dste; d_dstM = 4'hF;
  endtask

  function automatic logic [63:0] rnd_val();
    case ($urandom_range(0, 4))
      0:       return {$urandom, $urandom};
      1:       return 64'($urandom_range(0, 3));
      2:       return 64'h7FFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 1));
      3:       return {$urandom, 16'h0, 16'h7FFF + 16'($urandom_range(0, 2))};
      default: return 64'h8000_0000_0000_0000 + 64'($urandom_range(0, 1));
    endcase
  endfunction

  initial begin
    reset = 1'b1; E_stall = 1'b0; E_bubble = 1'b0;
    m_stat = 3'd1; W_stat = 3'd1;
    load(4'h0, 4'h0, 64'd0, 64'd0, 4'hF);
    tick(); tick();
    reset = 1'b0;
    chk("rst_icode", 64'(e_icode), 64'h1);
    chk("rst_stat",  64'(e_stat),  64'h1);
    chk("rst_dstE",  64'(e_dstE),  64'hF);
    chk("rst_cc",    64'(cc),      64'h4);

    load(4'h6, 4'h1, 64'd92, 64'd4, 4'h2);
    tick();
    chk("sub_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFA8);
    chk("sub_cnd",  64'(e_Cnd), 64'h0);
    load(4'h2, 4'h1, 64'h456, 64'd0, 4'h3);
    tick();
    chk("sub_cc",    64'(cc), 64'h2);
    chk("cmovle_cnd", 64'(e_Cnd), 64'h1);
    chk("cmovle_valE", e_valE, 64'h456);
    chk("cmovle_dstE", 64'(e_dstE), 64'h3);
    load(4'h2, 4'h6, 64'h666, 64'd0, 4'h5);
    tick();
    chk("cmovg_cnd",  64'(e_Cnd), 64'h0);
    chk("cmovg_valE", e_valE, 64'h666);
    chk("cmovg_dstE", 64'(e_dstE), 64'hF);

    load(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'h1);
    tick();
    chk("ovf_valE", e_valE, 64'h8000_0000_0000_0000);
    load(4'h6, 4'h1, 64'd5, 64'd5, 4'h1);
    tick();
    chk("ovf_cc", 64'(cc), 64'h3);
    m_stat = 3'd3;
    load(4'h1, 4'h0, 64'd0, 64'd0, 4'hF);
    tick();
    chk("mstat_hold_cc", 64'(cc), 64'h3);
    m_stat = 3'd1;
    load(4'h6, 4'h1, 64'd5, 64'd5, 4'h1);
    tick();
    load(4'h1, 4'h0, 64'd0, 64'd0, 4'hF);
    tick();
    chk("sub0_cc", 64'(cc), 64'h4);
    load(4'h6, 4'h1, 64'd92, 64'd4, 4'h1);
    tick();
    W_stat = 3'd2;
    load(4'h1, 4'h0, 64'd0, 64'd0, 4'hF);
    tick();
    chk("wstat_hold_cc", 64'(cc), 64'h4);
    W_stat = 3'd1;
    load(4'h6, 4'h1, 64'd92, 64'd4, 4'h1);
    d_stat = 3'd3;
    tick();
    chk("estat_pass", 64'(e_stat), 64'h3);
    load(4'h1, 4'h0, 64'd0, 64'd0, 4'hF);
    tick();
    chk("estat_hold_cc", 64'(cc), 64'h4);

    load(4'hA, 4'h0, 64'd0, 64'h100, 4'h4);
    tick();
    chk("push_valE", e_valE, 64'hF8);
    E_stall = 1'b1;
    load(4'h6, 4'h3, 64'd1, 64'd2, 4'h7);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("stall_valE",  e_valE, 64'hF8);
      chk("stall_icode", 64'(e_icode), 64'hA);
    end
    E_bubble = 1'b1;
    tick();
    chk("bub_icode", 64'(e_icode), 64'h1);
    chk("bub_dstE",  64'(e_dstE),  64'hF);
    chk("bub_stat",  64'(e_stat),  64'h1);
    E_stall = 1'b0; E_bubble = 1'b0;

    load(4'h6, 4'h4, 64'd3, 64'h1001, 4'h1);
    tick();
    chk("shl16_valE", 64'(e16_valE), 64'h8008);
    chk("noext_valE", e_valE, 64'h1004);
    load(4'h6, 4'h0, 64'd3, 64'h1001, 4'h1);
    tick();
    chk("shl16_cc", 64'(cc16), 64'h2);
    chk("noext_cc", 64'(cc), 64'h0);
    reset = 1'b1; E_stall = 1'b1;
    tick();
    chk("midrst_cc16",    64'(cc16),      64'h4);
    chk("midrst_icode16", 64'(e16_icode), 64'h1);
    chk("midrst_cc64",    64'(cc),        64'h4);
    reset = 1'b0; E_stall = 1'b0;

    for (int n = 0; n < 3000; n++) begin
      reset    = ($urandom_range(0, 99) < 2);
      E_stall  = ($urandom_range(0, 99) < 15);
      E_bubble = ($urandom_range(0, 99) < 8);
      m_stat   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      W_stat   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      d_stat   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      d_icode  = ($urandom_range(0, 3) == 0) ? 4'h6 : 4'($urandom_range(0, 15));
      d_ifun   = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
      d_valC   = rnd_val();
      d_valA   = rnd_val();
      d_valB   = rnd_val();
      d_dstE   = 4'($urandom_range(0, 15));
      d_dstM   = 4'($urandom_range(0, 15));
      tick();
      check_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
